pipe_skid: RTL
==============

PIPE_SKID -- requirements
Module: pipe_skid

Interface
REQ-001 Parameter WIDTH, default 18: data path width in bits.
REQ-002 Parameter STAGE, default 1: 1 = registered two-entry skid stage; 0 = combinational pass-through.
REQ-003 CLK  input  1: single clock, all state updates on rising edge.
REQ-004 RST_N  input  1: reset, asynchronous, active-low.
REQ-005 CE  input  1: stage enable; low freezes the stage.
REQ-006 FLUSH  input  1: synchronous clear of all held entries.
REQ-007 IN_DATA  input  WIDTH: upstream data.
REQ-008 IN_VALID  input  1: upstream data valid.
REQ-009 IN_READY  output  1: stage accepts IN_DATA this cycle.
REQ-010 OUT_DATA  output  WIDTH: downstream data.
REQ-011 OUT_VALID  output  1: OUT_DATA valid.
REQ-012 OUT_READY  input  1: downstream accepts OUT_DATA this cycle.
REQ-013 OCCUPANCY  output  2: number of held entries, 0..2.

Function
REQ-014 An input transfer SHALL occur on a rising edge when IN_VALID && IN_READY; an output transfer SHALL occur when OUT_VALID && OUT_READY.
REQ-015 STAGE=1: the stage SHALL hold a main register (drives OUT_DATA) and a skid register, and track states EMPTY (0 entries), ONE (main full), TWO (main and skid full).
REQ-016 IN_READY SHALL be high in EMPTY and ONE and low in TWO, gated by CE; it SHALL depend only on state and CE, never combinationally on OUT_READY.
REQ-017 OUT_VALID SHALL be high in ONE and TWO, gated by CE.
REQ-018 EMPTY + input transfer -> ONE, main <= IN_DATA; no input -> stay EMPTY.
REQ-019 ONE: input only -> TWO, skid <= IN_DATA; output only -> EMPTY; input and output together -> ONE, main <= IN_DATA; neither -> hold.
REQ-020 TWO: output transfer -> ONE, main <= skid; otherwise hold (no input possible).
REQ-021 Latency SHALL be exactly 1 cycle from input transfer to OUT_VALID when EMPTY; throughput SHALL be one transfer per cycle with OUT_READY held high.
REQ-022 Data SHALL leave in exactly the order accepted; no entry lost or duplicated under any OUT_READY pattern.
REQ-023 CE=0: IN_READY and OUT_VALID SHALL read 0, no transfers occur, all registers and OCCUPANCY hold.
REQ-024 FLUSH=1 (with CE either value): next state EMPTY, OCCUPANCY 0; any simultaneous input or output transfer SHALL be discarded (FLUSH wins).
REQ-025 OCCUPANCY SHALL equal 0/1/2 for EMPTY/ONE/TWO.
REQ-026 OUT_DATA SHALL be unchanged while OUT_VALID=1 and OUT_READY=0.
REQ-027 STAGE=0: OUT_DATA=IN_DATA, OUT_VALID=IN_VALID&&CE, IN_READY=OUT_READY&&CE, OCCUPANCY=0, no registers; FLUSH ignored.

Reset
REQ-028 RST_N low SHALL immediately, without a clock edge, force state EMPTY, main and skid to 0, OUT_DATA 0, OUT_VALID 0, OCCUPANCY 0, IN_READY 0.
REQ-029 After RST_N deasserts, IN_READY SHALL rise on the first rising edge and acceptance SHALL begin on the following edge.
REQ-030 Reset asserted mid-operation (any state) SHALL discard held entries; no pre-reset data SHALL appear at OUT_DATA after release.

Verification
REQ-031 Streaming: CE=1, OUT_READY=1, IN_VALID=1 with IN_DATA 1,2,3,4 on consecutive cycles -> OUT_DATA 1,2,3,4 one cycle later, OUT_VALID continuous, OCCUPANCY 1.
REQ-032 Backpressure: OUT_READY=0, push 0x0A,0x0B -> OCCUPANCY 2, IN_READY 0, 0x0C held off; raise OUT_READY -> outputs 0x0A,0x0B,0x0C in order.
REQ-033 Simultaneous: ONE holding 0x11, input 0x22 with OUT_READY=1 -> 0x11 leaves, main=0x22, OCCUPANCY stays 1.
REQ-034 CE freeze: TWO holding 5,6, CE=0 for 3 cycles with OUT_READY=1 -> OUT_VALID 0, OCCUPANCY 2; CE=1 -> 5 then 6.
REQ-035 FLUSH in TWO with IN_VALID=1 and OUT_READY=1 -> next cycle OCCUPANCY 0, OUT_VALID 0, nothing emitted or accepted.
REQ-036 Async reset: RST_N pulsed low between edges in TWO -> outputs 0 immediately; after release, only newly pushed data appears.

Source files
------------

// File: rtl/pipe_skid_if.sv
// Valid/ready handshake bundle used on both sides of the skid stage.
// master drives data/valid and receives ready; slave is the mirror image.
interface pipe_skid_if #(
   parameter int WIDTH = 18
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pipe_skid.sv
// Two-entry skid stage between an upstream and a downstream valid/ready
// channel. STAGE=1 registers the path with a main and a skid register, so
// upstream ready never depends combinationally on downstream ready.
// STAGE=0 degenerates to a gated wire-through with no state.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_EMPTY | nothing held; out_valid low, ready once out of reset
// S_ONE   | main register holds the head entry; ready and valid
// S_TWO   | main and skid both full; upstream stalled, downstream valid
module pipe_skid #(
   parameter int WIDTH = 18,
   parameter int STAGE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic        flush,
   pipe_skid_if.slave  up,
   pipe_skid_if.master down,
   output logic [1:0]  occupancy
);

   generate
      if (STAGE == 0) begin : g_pass
         assign down.data  = up.data;
         assign down.valid = up.valid && ce;
         assign up.ready   = down.ready && ce;
         assign occupancy  = 2'd0;
      end else begin : g_reg
         typedef enum logic [1:0] {
            S_EMPTY = 2'd0,
            S_ONE   = 2'd1,
            S_TWO   = 2'd2
         } state_t;

         state_t           state_q, state_d;
         logic [WIDTH-1:0] main_q, main_d;
         logic [WIDTH-1:0] skid_q, skid_d;
         // Holds ready low until the first edge after reset release, so
         // acceptance can only start on the edge after that.
         logic             started_q;
         logic             in_ready;
         logic             out_valid;
         logic             in_xfer;
         logic             out_xfer;

         // Handshake outputs come from state and ce only.
         always_comb begin
            in_ready  = started_q && ce && (state_q != S_TWO);
            out_valid = ce && (state_q != S_EMPTY);
            in_xfer   = in_ready && up.valid;
            out_xfer  = out_valid && down.ready;
         end

         assign up.ready   = in_ready;
         assign down.valid = out_valid;
         assign down.data  = main_q;
         assign occupancy  = state_q;

         // Next-state and register-load decisions; flush overrides any transfer.
         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
               state_d = S_EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end else begin
               case (state_q)
                  S_EMPTY: begin
                     if (in_xfer) begin
                        state_d = S_ONE;
                        main_d  = up.data;
                     end
                  end
                  S_ONE: begin
                     if (in_xfer && out_xfer) begin
                        main_d = up.data;
                     end else if (in_xfer) begin
                        state_d = S_TWO;
                        skid_d  = up.data;
                     end else if (out_xfer) begin
                        state_d = S_EMPTY;
                     end
                  end
                  S_TWO: begin
                     if (out_xfer) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                     end
                  end
                  default: begin
                     state_d = S_EMPTY;
                  end
               endcase
            end
         end

         // State and data registers; reset clears everything immediately.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q   <= S_EMPTY;
               main_q    <= '0;
               skid_q    <= '0;
               started_q <= 1'b0;
            end else begin
               state_q   <= state_d;
               main_q    <= main_d;
               skid_q    <= skid_d;
               started_q <= 1'b1;
            end
         end
      end
   endgenerate

endmodule
